seq_div: RTL and testbench
==========================

SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 SHALL have parameter WIDTH, default 8, setting operand, quotient and remainder width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port write  input  1  request: start a division with the current dividend/divisor.
REQ-005 SHALL have port dividend  input  WIDTH  unsigned dividend, sampled only on an accepted write.
REQ-006 SHALL have port divisor  input  WIDTH  unsigned divisor, sampled only on an accepted write.
REQ-007 SHALL have port quotient  output  WIDTH  unsigned quotient of the last completed operation.
REQ-008 SHALL have port remainder  output  WIDTH  unsigned remainder of the last completed operation.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when quotient/remainder update.
REQ-011 SHALL have port div_zero  output  1  high with the result of an operation whose divisor was 0, held until next completion.

Function
REQ-012 SHALL implement an FSM with states IDLE and RUN, plus an iteration counter 0..WIDTH-1.
REQ-013 SHALL accept write only on a rising edge where state is IDLE; this edge is edge k; dividend and divisor latch, busy=1 from edge k.
REQ-014 SHALL ignore write while busy=1: no relatch, no restart, outputs unaffected.
REQ-015 SHALL compute by restoring division, one quotient bit per cycle, MSB first: partial remainder (WIDTH+1 bits) shifted left with next dividend bit, divisor subtracted, quotient bit=1 and difference kept if non-negative, else bit=0 and value restored.
REQ-016 SHALL perform iterations on edges k+1..k+WIDTH; at edge k+WIDTH, quotient/remainder/div_zero update, done=1 for exactly one cycle, busy=0, state=IDLE.
REQ-017 SHALL for divisor 0 skip iteration: at edge k+1, quotient=all ones, remainder=dividend, div_zero=1, done pulse, busy=0.
REQ-018 SHALL guarantee quotient*divisor+remainder==dividend and remainder<divisor for every divisor!=0.
REQ-019 SHALL hold quotient, remainder and div_zero stable between done pulses, including during a following operation.
REQ-020 SHALL accept a write asserted in the cycle done is high (state already IDLE), giving back-to-back throughput of one result per WIDTH+1 cycles.
REQ-021 SHALL keep done low in any cycle not produced by REQ-016/REQ-017.

Reset
REQ-022 SHALL, while reset=0, asynchronously force state=IDLE, counter=0, busy=0, done=0, div_zero=0, quotient=0, remainder=0, internal registers=0.
REQ-023 SHALL abandon any in-flight operation on reset with no done pulse; first write accepted on first rising edge after reset deasserts.

Structure
REQ-024 SHALL take WIDTH default and the FSM state enumeration from shared package seq_arith_pkg, also used by seq_mul.
REQ-025 SHALL place one restoring step (shift, trial subtract, select, quotient bit) in combinational sub-module div_step; seq_div holds FSM, counter and registers.

Verification
REQ-026 Reset low then high, write with dividend=56, divisor=7 -> done at edge k+8, quotient=8, remainder=0, div_zero=0; inverts 8x7.
REQ-027 Second instance, dividend=110, divisor=11 -> quotient=10, remainder=0 at edge k+8; dividend=100, divisor=7 -> quotient=14, remainder=2.
REQ-028 dividend=3, divisor=200 -> quotient=0, remainder=3; dividend=255, divisor=1 -> quotient=255, remainder=0.
REQ-029 dividend=42, divisor=0 -> done at edge k+1, quotient=255, remainder=42, div_zero=1; next valid op clears div_zero.
REQ-030 Write held high through busy with changing operands -> only first operands used, done once per accepted write, back-to-back second op accepted on the done cycle.
REQ-031 reset=0 at edge k+4 of a 56/7 op -> outputs immediately 0, no done pulse, new write after release completes normally.

Source files
------------

// File: rtl/seq_arith_pkg.sv
// rtl/seq_arith_pkg.sv - shared widths, FSM states and helpers for the sequential arithmetic units
package seq_arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_e;

    // Iteration counters need at least one bit even for a 1-bit datapath.
    function automatic int cnt_bits(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division step: shift in a dividend bit, trial subtract, select
module div_step
    import seq_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // One extra bit above the partial remainder acts as the borrow/sign of the trial subtract.
    assign shifted = {rem_in, bit_in};
    assign diff    = shifted - {2'b00, divisor};
    assign q_bit   = ~diff[WIDTH+1];
    assign rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/seq_div.sv
// rtl/seq_div.sv - sequential restoring divider, one quotient bit per clock, MSB first
module seq_div
    import seq_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int            CW   = cnt_bits(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    seq_state_e       state;
    seq_state_e       state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dsr_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH:0]   rem_step;
    logic             q_bit;
    logic             accept;
    logic             finish;
    logic             zero_op;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_in (rem_q),
        .bit_in (dvd_q[WIDTH-1]),
        .divisor(dsr_q),
        .rem_out(rem_step),
        .q_bit  (q_bit)
    );

    assign zero_op = (dsr_q == '0);
    assign busy    = (state == ST_RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (write) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // A zero divisor bypasses the iteration loop entirely.
                if (zero_op || count == LAST) begin
                    finish     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                dvd_q <= dividend;
                dsr_q <= divisor;
                quo_q <= '0;
                rem_q <= '0;
                count <= '0;
            end else if (state == ST_RUN) begin
                if (zero_op) begin
                    quotient  <= '1;
                    remainder <= dvd_q;
                    div_zero  <= 1'b1;
                    done      <= 1'b1;
                end else begin
                    rem_q <= rem_step;
                    dvd_q <= dvd_q << 1;
                    quo_q <= (quo_q << 1) | WIDTH'(q_bit);
                    count <= count + 1'b1;
                    if (finish) begin
                        // Publish the final step directly so results land on the last iteration edge.
                        quotient  <= (quo_q << 1) | WIDTH'(q_bit);
                        remainder <= rem_step[WIDTH-1:0];
                        div_zero  <= 1'b0;
                        done      <= 1'b1;
                        count     <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// tb/tb_seq_div.sv - randomized and directed self-checking bench for seq_div
module tb_seq_div;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         write;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_zero;

    int n_cmp = 0;
    int n_bad = 0;
    bit running = 1'b0;

    logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
    logic         m_dz = 1'b0, p_dz = 1'b0, m_done = 1'b0, m_busy = 1'b0;
    int           m_left = 0;

    seq_div #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .write    (write),
        .dividend (dividend),
        .divisor  (divisor),
        .quotient (quotient),
        .remainder(remainder),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an accepted op yields its result after a fixed number of edges.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 1'b0; m_left = 0; m_done = 1'b0;
            m_q = '0; m_r = '0; m_dz = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_q = p_q; m_r = p_r; m_dz = p_dz;
                    m_done = 1'b1;
                    m_busy = 1'b0;
                end
            end else if (write) begin
                if (divisor == 0) begin
                    p_q = '1; p_r = dividend; p_dz = 1'b1; m_left = 1;
                end else begin
                    p_q = dividend / divisor; p_r = dividend % divisor; p_dz = 1'b0; m_left = W;
                end
                m_busy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (running) begin
            chk("model_done", done, m_done);
            chk("model_busy", busy, m_busy);
            chk("model_quotient", quotient, m_q);
            chk("model_remainder", remainder, m_r);
            chk("model_div_zero", div_zero, m_dz);
        end
    end

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input int eq, input int er,
                      input int edz, input int elat);
        int lat;
        @(negedge clk);
        write = 1'b1; dividend = a; divisor = b;
        @(posedge clk);
        @(negedge clk);
        write = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("op_latency", lat, elat);
        chk("op_quotient", quotient, eq);
        chk("op_remainder", remainder, er);
        chk("op_div_zero", div_zero, edz);
    endtask

    initial begin
        int ndone;
        reset = 1'b0; write = 1'b0; dividend = '0; divisor = '0;
        #1;
        chk("reset_quotient", quotient, 0);
        chk("reset_remainder", remainder, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_div_zero", div_zero, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        running = 1'b1;

        op(8'd56, 8'd7, 8, 0, 0, 8);
        op(8'd110, 8'd11, 10, 0, 0, 8);
        op(8'd100, 8'd7, 14, 2, 0, 8);
        op(8'd3, 8'd200, 0, 3, 0, 8);
        op(8'd255, 8'd1, 255, 0, 0, 8);
        op(8'd42, 8'd0, 255, 42, 1, 1);
        op(8'd100, 8'd7, 14, 2, 0, 8);

        // Write held high: second op must be taken on the done cycle of the first.
        @(negedge clk);
        write = 1'b1; dividend = 8'd56; divisor = 8'd7;
        @(posedge clk);
        ndone = 0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    chk("held_first_quotient", quotient, 8);
                    chk("held_first_remainder", remainder, 0);
                    chk("held_first_at", i, 8);
                end
            end
            dividend = W'($urandom);
            divisor = W'($urandom_range(1, 255));
        end
        write = 1'b0;
        chk("held_done_count", ndone, 2);
        repeat (3) @(negedge clk);

        // Reset in the middle of an operation.
        op(8'd200, 8'd3, 66, 2, 0, 8);
        @(negedge clk);
        write = 1'b1; dividend = 8'd56; divisor = 8'd7;
        @(posedge clk);
        @(negedge clk);
        write = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("midreset_quotient", quotient, 0);
        chk("midreset_remainder", remainder, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_done", done, 0);
        @(negedge clk);
        reset = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midreset_no_done", ndone, 0);
        op(8'd56, 8'd7, 8, 0, 0, 8);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            write = ($urandom_range(0, 3) != 0);
            dividend = W'($urandom);
            divisor = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
        end
        @(negedge clk);
        write = 1'b0;
        repeat (12) @(negedge clk);
        running = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
